line_tap_buffer: RTL and testbench
==================================

Name: line_tap_buffer

Overview:
- Cascaded, multi-tap shift-register line buffer, the parametrised successor to the single-output shift register used in the image pipeline.
- Holds TAPS rows of DEPTH words each, chained end to end, and exposes the last word of every row simultaneously. Downstream window/convolution logic gets vertically aligned pixels.
- Tracks fill level, so consumers know when each tap, and the full window, holds real data rather than reset zeros.
- Adds a synchronous flush for frame boundaries.

Parameters:
- WIDTH, 12, bits per word (pixel).
- DEPTH, 640, words per row (line length); must be >= 1.
- TAPS, 3, number of rows/taps; must be >= 1.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_flush  input  1  synchronous clear of storage and fill state.
- i_shift  input  1  advance the chain by one word.
- i_wdata  input  WIDTH  word entering stage 0.
- o_taps  output  TAPS*WIDTH  packed taps; bits [k*WIDTH +: WIDTH] = tap k.
- o_tap_valid  output  TAPS  bit k high when tap k holds written data.
- o_valid  output  1  all taps valid (chain completely filled).
- o_fill_cnt  output  $clog2(TAPS*DEPTH+1)  shifts since last reset/flush, saturating.

Behaviour:
- One clock: i_clk. Reset is synchronous and active-high (i_rst), sampled only on the rising edge of i_clk.
- Storage: linear chain of N = TAPS*DEPTH stages, stage[0..N-1], each WIDTH bits.
- On an edge with i_shift=1 (no reset, no flush):
  - stage[0] <= i_wdata.
  - stage[j] <= stage[j-1] for j = 1..N-1.
- With i_shift=0, all stages hold.
- Tap k = stage[(k+1)*DEPTH - 1], driven straight from registers; no combinational path from inputs.
- Latency: a word written on shift edge n appears on tap k after edge n + (k+1)*DEPTH - 1. Equivalently, it is the tap-k output after exactly (k+1)*DEPTH shift edges, counting its own write edge. Counting is in shifts, not cycles.
- DEPTH=1: the taps are consecutive stages. TAPS=1: plain DEPTH-deep shift register with fill tracking.
- Fill counter:
  - Increments by 1 on each accepted shift.
  - Saturates at N and never wraps; further shifts keep it at N.
- o_tap_valid[k] = (o_fill_cnt >= (k+1)*DEPTH). o_valid = (o_fill_cnt == N), equal to o_tap_valid[TAPS-1]. Both are derived combinationally from the registered count.
- Reset (i_rst=1 at edge): all stages <= 0 and fill count <= 0. Consequently o_taps=0, o_tap_valid=0, o_valid=0, o_fill_cnt=0.
- Flush (i_flush=1 at edge): identical effect to reset.
- Priority: i_rst > i_flush > i_shift.
  - Shift coincident with flush is discarded; i_wdata is not captured.
  - Reset or flush mid-fill or after saturation returns to the empty state on that edge.
- Edge after a flush with i_shift=1: normal shift, fill count 1.
- Reset asserted for multiple cycles: state held at zero throughout, regardless of i_shift/i_flush.
- Initial state before the first reset is undefined; the bench must apply reset first.
- Width rule: o_fill_cnt width is $clog2(N+1); comparisons are done at that width.

Test Plan:
- Config WIDTH=8, DEPTH=4, TAPS=3. Reset, then shift 1,2,3,... one per cycle.
  - After 4 shifts: tap0=1, o_tap_valid=3'b001.
  - After 8 shifts: tap0=5, tap1=1, o_tap_valid=3'b011.
  - After 12 shifts: taps = 9,5,1, o_valid=1, o_fill_cnt=12.
- Same config, 20 shifts of values 1..20:
  - o_fill_cnt stays 12 (saturated).
  - taps = 17,13,9; o_valid remains 1.
- Gapped shifting: shift 1..6 with i_shift=0 for 3 cycles between each shift.
  - Outputs hold during gaps.
  - After the 6th shift: tap0=3, o_tap_valid=3'b001, o_fill_cnt=6.
- Flush: fill to 12, then assert i_flush together with i_shift (wdata=0xAA).
  - Next cycle: all taps 0, o_fill_cnt=0, o_valid=0.
  - 0xAA never appears on any tap in the following 12 shifts, which use new data.
- Mid-operation reset: after 7 shifts, hold i_rst=1 for 2 cycles with i_shift=1 and i_flush=1.
  - All outputs 0 during and after.
  - Refill from 1: tap0=1 after 4 shifts.
- Degenerate config DEPTH=1, TAPS=1, WIDTH=16. Shift 0xBEEF.
  - Next cycle: tap0=0xBEEF, o_valid=1, o_fill_cnt=1.
  - A further shift of 0x1234 gives tap0=0x1234 and o_fill_cnt=1 (saturated).

Source files
------------

// File: rtl/line_tap_buffer.sv
// Cascaded multi-tap line buffer: TAPS rows of DEPTH words chained end to end,
// exposing the last word of every row plus fill-level tracking and a synchronous flush.
module line_tap_buffer #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 640,
    parameter int TAPS  = 3
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_flush,
    input  logic                                i_shift,
    input  logic [WIDTH-1:0]                    i_wdata,
    output logic [TAPS*WIDTH-1:0]               o_taps,
    output logic [TAPS-1:0]                     o_tap_valid,
    output logic                                o_valid,
    output logic [$clog2(TAPS*DEPTH+1)-1:0]     o_fill_cnt
);

    localparam int N  = TAPS * DEPTH;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] FILL_MAX = CW'(N);

    // Kept in flops rather than RAM so that a flush can clear every stage in one edge.
    logic [WIDTH-1:0] stage_reg [N];
    logic [CW-1:0]    fill_cnt_reg;
    logic [CW-1:0]    fill_cnt_next;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            for (int j = 0; j < N; j++) begin
                stage_reg[j] <= '0;
            end
        end else if (i_shift) begin
            stage_reg[0] <= i_wdata;
            for (int j = 1; j < N; j++) begin
                stage_reg[j] <= stage_reg[j-1];
            end
        end
    end

    always_comb begin
        fill_cnt_next = fill_cnt_reg;
        if (i_shift && (fill_cnt_reg != FILL_MAX)) begin
            fill_cnt_next = fill_cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            fill_cnt_reg <= '0;
        end else begin
            fill_cnt_reg <= fill_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            localparam logic [CW-1:0] TAP_THRESH = CW'((gi + 1) * DEPTH);
            assign o_taps[gi*WIDTH +: WIDTH] = stage_reg[(gi+1)*DEPTH - 1];
            assign o_tap_valid[gi]           = (fill_cnt_reg >= TAP_THRESH);
        end
    endgenerate

    assign o_valid    = (fill_cnt_reg == FILL_MAX);
    assign o_fill_cnt = fill_cnt_reg;

endmodule

// File: tb/tb_line_tap_buffer.sv
// Directed bench for line_tap_buffer: a 3x4 byte configuration and a degenerate 1x1 16-bit one.
module tb_line_tap_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Config A: WIDTH=8, DEPTH=4, TAPS=3
    logic        a_rst = 1'b1, a_flush = 1'b0, a_shift = 1'b0;
    logic [7:0]  a_wdata = '0;
    logic [23:0] a_taps;
    logic [2:0]  a_tap_valid;
    logic        a_valid;
    logic [3:0]  a_fill_cnt;

    // Config B: WIDTH=16, DEPTH=1, TAPS=1
    logic        b_rst = 1'b1, b_flush = 1'b0, b_shift = 1'b0;
    logic [15:0] b_wdata = '0;
    logic [15:0] b_taps;
    logic [0:0]  b_tap_valid;
    logic        b_valid;
    logic [0:0]  b_fill_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;

    line_tap_buffer #(.WIDTH(8), .DEPTH(4), .TAPS(3)) u_dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_flush(a_flush), .i_shift(a_shift), .i_wdata(a_wdata),
        .o_taps(a_taps), .o_tap_valid(a_tap_valid), .o_valid(a_valid), .o_fill_cnt(a_fill_cnt)
    );

    line_tap_buffer #(.WIDTH(16), .DEPTH(1), .TAPS(1)) u_dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_flush(b_flush), .i_shift(b_shift), .i_wdata(b_wdata),
        .o_taps(b_taps), .o_tap_valid(b_tap_valid), .o_valid(b_valid), .o_fill_cnt(b_fill_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock for config A; outputs are sampled 1 ns after the edge.
    task automatic cyc_a(input logic rst, input logic flush, input logic shift, input logic [7:0] d);
        a_rst = rst; a_flush = flush; a_shift = shift; a_wdata = d;
        @(posedge clk); #1;
        $display("A rst=%0b flush=%0b shift=%0b wdata=%02h -> taps=%06h tv=%03b valid=%0b fill=%0d",
                 rst, flush, shift, d, a_taps, a_tap_valid, a_valid, a_fill_cnt);
    endtask

    task automatic cyc_b(input logic rst, input logic flush, input logic shift, input logic [15:0] d);
        b_rst = rst; b_flush = flush; b_shift = shift; b_wdata = d;
        @(posedge clk); #1;
        $display("B rst=%0b flush=%0b shift=%0b wdata=%04h -> taps=%04h tv=%0b valid=%0b fill=%0d",
                 rst, flush, shift, d, b_taps, b_tap_valid, b_valid, b_fill_cnt);
    endtask

    initial begin
        logic [23:0] exp_taps;

        // Reset state
        cyc_a(1, 0, 0, 8'h00);
        cyc_a(1, 0, 1, 8'h77);
        check("a_rst_taps", a_taps, 24'h0);
        check("a_rst_tv", a_tap_valid, 3'b000);
        check("a_rst_valid", a_valid, 1'b0);
        check("a_rst_fill", a_fill_cnt, 4'd0);

        // Fill with 1..20, one per cycle
        for (int s = 1; s <= 20; s++) begin
            cyc_a(0, 0, 1, 8'(s));
            if (s == 4) begin
                check("a_s4_taps", a_taps, {8'd0, 8'd0, 8'd1});
                check("a_s4_tv", a_tap_valid, 3'b001);
                check("a_s4_fill", a_fill_cnt, 4'd4);
            end
            if (s == 8) begin
                check("a_s8_taps", a_taps, {8'd0, 8'd1, 8'd5});
                check("a_s8_tv", a_tap_valid, 3'b011);
            end
            if (s == 12) begin
                check("a_s12_taps", a_taps, {8'd1, 8'd5, 8'd9});
                check("a_s12_valid", a_valid, 1'b1);
                check("a_s12_fill", a_fill_cnt, 4'd12);
            end
            if (s > 12) check("a_sat_fill", a_fill_cnt, 4'd12);
        end
        check("a_s20_taps", a_taps, {8'd9, 8'd13, 8'd17});
        check("a_s20_valid", a_valid, 1'b1);
        check("a_s20_tv", a_tap_valid, 3'b111);

        // Flush coincident with shift of 0xAA
        cyc_a(0, 1, 1, 8'hAA);
        check("a_fl_taps", a_taps, 24'h0);
        check("a_fl_fill", a_fill_cnt, 4'd0);
        check("a_fl_valid", a_valid, 1'b0);
        for (int s = 1; s <= 12; s++) begin
            cyc_a(0, 0, 1, 8'(8'h30 + s));
            check("a_fl_noaa", ((a_taps[7:0] == 8'hAA) || (a_taps[15:8] == 8'hAA) ||
                                (a_taps[23:16] == 8'hAA)), 1'b0);
            if (s == 1) check("a_fl_fill1", a_fill_cnt, 4'd1);
        end
        check("a_fl_refill", a_taps, {8'h31, 8'h35, 8'h39});

        // Gapped shifting: 1..6 with three idle cycles after each shift
        cyc_a(1, 0, 0, 8'h00);
        for (int s = 1; s <= 6; s++) begin
            exp_taps = (s >= 4) ? 24'(s - 3) : 24'h0;
            cyc_a(0, 0, 1, 8'(s));
            check("a_gap_taps", a_taps, exp_taps);
            check("a_gap_fill", a_fill_cnt, 4'(s));
            if (s < 6) begin
                for (int g = 0; g < 3; g++) begin
                    cyc_a(0, 0, 0, 8'hEE);
                    check("a_gap_hold_taps", a_taps, exp_taps);
                    check("a_gap_hold_fill", a_fill_cnt, 4'(s));
                end
            end
        end
        check("a_gap_tap0", a_taps[7:0], 8'd3);
        check("a_gap_tv", a_tap_valid, 3'b001);

        // Mid-operation reset dominating shift and flush
        cyc_a(1, 0, 0, 8'h00);
        for (int s = 1; s <= 7; s++) cyc_a(0, 0, 1, 8'(s));
        check("a_pre_rst_fill", a_fill_cnt, 4'd7);
        for (int r = 0; r < 2; r++) begin
            cyc_a(1, 1, 1, 8'h55);
            check("a_mrst_taps", a_taps, 24'h0);
            check("a_mrst_fill", a_fill_cnt, 4'd0);
            check("a_mrst_tv", {a_tap_valid, a_valid}, 4'h0);
        end
        cyc_a(0, 0, 0, 8'h00);
        check("a_post_rst_taps", a_taps, 24'h0);
        for (int s = 1; s <= 4; s++) begin
            cyc_a(0, 0, 1, 8'(s));
            if (s == 1) check("a_refill_fill1", a_fill_cnt, 4'd1);
        end
        check("a_refill_tap0", a_taps[7:0], 8'd1);
        check("a_refill_tv", a_tap_valid, 3'b001);

        // Degenerate configuration
        cyc_b(1, 0, 0, 16'h0000);
        check("b_rst_taps", b_taps, 16'h0);
        check("b_rst_fill", b_fill_cnt, 1'b0);
        check("b_rst_valid", b_valid, 1'b0);
        cyc_b(0, 0, 1, 16'hBEEF);
        check("b_beef_taps", b_taps, 16'hBEEF);
        check("b_beef_valid", b_valid, 1'b1);
        check("b_beef_tv", b_tap_valid, 1'b1);
        check("b_beef_fill", b_fill_cnt, 1'b1);
        cyc_b(0, 0, 1, 16'h1234);
        check("b_1234_taps", b_taps, 16'h1234);
        check("b_1234_fill", b_fill_cnt, 1'b1);
        cyc_b(0, 0, 0, 16'hFFFF);
        check("b_hold_taps", b_taps, 16'h1234);
        cyc_b(0, 1, 1, 16'hFFFF);
        check("b_flush_taps", b_taps, 16'h0);
        check("b_flush_valid", b_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
